// File: rtl/clk_period_meter_pkg.sv
// Shared types and defaults for the clk_period_meter slice.
// Optional macro PERIOD_AVG_EN (used in clk_period_meter.sv) averages every four periods.
`timescale 1ns/1ps
package clk_period_meter_pkg;

    localparam int CPM_CNT_W   = 16;
    localparam int CPM_TIMEOUT = 65535;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } cpm_state_t;

endpackage

// File: rtl/clk_period_meter_if.sv
// Measurement result handshake plus status flags between the meter and its consumer.
`timescale 1ns/1ps
interface clk_period_meter_if #(
    parameter int CNT_W = clk_period_meter_pkg::CPM_CNT_W
) ();

    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             period_ready;
    logic             timeout;
    logic             lock;
    logic             overrun;

    modport master (
        output period,
        output period_valid,
        output timeout,
        output lock,
        output overrun,
        input  period_ready
    );

    modport slave (
        input  period,
        input  period_valid,
        input  timeout,
        input  lock,
        input  overrun,
        output period_ready
    );

endinterface

// File: rtl/clk_period_meter_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by a registered rising-edge pulse.
// Latency from an input rise to the pulse is SYNC_STAGES+1 clocks.
`timescale 1ns/1ps
module clk_period_meter_sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk50,
    input  logic rst_n,
    input  logic async_sig,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   last_r;

    // Synchronizer chain, delayed last stage and edge pulse register.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            sync_r     <= '0;
            last_r     <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync_r     <= {sync_r[SYNC_STAGES-2:0], async_sig};
            last_r     <= sync_r[SYNC_STAGES-1];
            rise_pulse <= sync_r[SYNC_STAGES-1] & ~last_r;
        end
    end

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of an asynchronous clock in clk50 cycles, with timeout, lock and overrun flags.
// Define PERIOD_AVG_EN to report the truncated mean of every four consecutive periods.
`timescale 1ns/1ps
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int CNT_W       = CPM_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = CPM_TIMEOUT
) (
    input  logic               clk50,
    input  logic               rst_n,
    input  logic               clk_in,
    input  logic               enable,
    clk_period_meter_if.master pm
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);

    cpm_state_t       state_r;
    cpm_state_t       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             edge_s;

    logic             cnt_zero_s;
    logic             cnt_load_s;
    logic             cnt_inc_s;
    logic             take_s;
    logic             to_set_s;
    logic             to_clr_s;
    logic             hist_clr_s;

    logic             rep_s;
    logic [CNT_W-1:0] rep_val_s;

    logic [CNT_W-1:0] period_r;
    logic             valid_r;
    logic             timeout_r;
    logic             lock_r;
    logic             overrun_r;
    logic             have_prev_r;

    clk_period_meter_sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk50      (clk50),
        .rst_n      (rst_n),
        .async_sig  (clk_in),
        .rise_pulse (edge_s)
    );

    // FSM state register.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; dropping enable always returns to IDLE.
    always_comb begin
        state_s = state_r;
        if (!enable) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_s = ST_ARM;
                ST_ARM: begin
                    if (edge_s) begin
                        state_s = ST_MEASURE;
                    end else begin
                        state_s = ST_ARM;
                    end
                end
                ST_MEASURE: begin
                    if (edge_s) begin
                        state_s = ST_MEASURE;
                    end else if (cnt_r == TO_LAST) begin
                        state_s = ST_ARM;
                    end else begin
                        state_s = ST_MEASURE;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Per-state control strobes for the counter, timeout and measurement path.
    always_comb begin
        cnt_zero_s = 1'b0;
        cnt_load_s = 1'b0;
        cnt_inc_s  = 1'b0;
        take_s     = 1'b0;
        to_set_s   = 1'b0;
        to_clr_s   = 1'b0;
        hist_clr_s = 1'b0;
        if (!enable) begin
            cnt_zero_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: cnt_zero_s = 1'b1;
                ST_ARM: begin
                    if (edge_s) begin
                        cnt_load_s = 1'b1;
                        to_clr_s   = 1'b1;
                    end else if (cnt_r != TO_MAX) begin
                        cnt_inc_s  = 1'b1;
                        to_set_s   = (cnt_r == TO_LAST);
                        hist_clr_s = (cnt_r == TO_LAST);
                    end else begin
                        cnt_inc_s  = 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (edge_s) begin
                        take_s     = 1'b1;
                        cnt_load_s = 1'b1;
                    end else if (cnt_r == TO_LAST) begin
                        cnt_inc_s  = 1'b1;
                        to_set_s   = 1'b1;
                        hist_clr_s = 1'b1;
                    end else begin
                        cnt_inc_s  = 1'b1;
                    end
                end
                default: cnt_zero_s = 1'b1;
            endcase
        end
    end

    // Period counter; saturates at TIMEOUT because the FSM stops incrementing there.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (cnt_zero_s) begin
            cnt_r <= '0;
        end else if (cnt_load_s) begin
            cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

`ifdef PERIOD_AVG_EN
    logic [CNT_W+1:0] acc_r;
    logic [CNT_W+1:0] sum_s;
    logic [1:0]       avg_n_r;

    // Only every fourth measurement produces a report of the truncated mean.
    always_comb begin
        sum_s     = acc_r + {2'b00, cnt_r};
        rep_s     = take_s && (avg_n_r == 2'd3);
        rep_val_s = sum_s[CNT_W+1:2];
    end

    // Accumulator and measurement count; cleared by timeout or disable.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= '0;
            avg_n_r <= 2'd0;
        end else if (!enable || hist_clr_s) begin
            acc_r   <= '0;
            avg_n_r <= 2'd0;
        end else if (take_s) begin
            if (avg_n_r == 2'd3) begin
                acc_r   <= '0;
                avg_n_r <= 2'd0;
            end else begin
                acc_r   <= sum_s;
                avg_n_r <= avg_n_r + 2'd1;
            end
        end else begin
            acc_r   <= acc_r;
            avg_n_r <= avg_n_r;
        end
    end
`else
    // Every measurement is reported as-is.
    always_comb begin
        rep_s     = take_s;
        rep_val_s = cnt_r;
    end
`endif

    // Result, handshake and status flag registers; period keeps its value when disabled.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            period_r    <= '0;
            valid_r     <= 1'b0;
            timeout_r   <= 1'b0;
            lock_r      <= 1'b0;
            overrun_r   <= 1'b0;
            have_prev_r <= 1'b0;
        end else if (!enable) begin
            period_r    <= period_r;
            valid_r     <= 1'b0;
            timeout_r   <= 1'b0;
            lock_r      <= 1'b0;
            overrun_r   <= 1'b0;
            have_prev_r <= 1'b0;
        end else begin
            if (to_set_s) begin
                timeout_r <= 1'b1;
            end else if (to_clr_s) begin
                timeout_r <= 1'b0;
            end else begin
                timeout_r <= timeout_r;
            end

            if (hist_clr_s) begin
                lock_r      <= 1'b0;
                have_prev_r <= 1'b0;
            end else if (rep_s) begin
                lock_r      <= have_prev_r && (rep_val_s == period_r);
                have_prev_r <= 1'b1;
            end else begin
                lock_r      <= lock_r;
                have_prev_r <= have_prev_r;
            end

            // A new report landing on an accepted cycle simply replaces it without overrun.
            if (rep_s) begin
                period_r  <= rep_val_s;
                valid_r   <= 1'b1;
                overrun_r <= overrun_r | (valid_r & ~pm.period_ready);
            end else if (valid_r && pm.period_ready) begin
                period_r  <= period_r;
                valid_r   <= 1'b0;
                overrun_r <= overrun_r;
            end else begin
                period_r  <= period_r;
                valid_r   <= valid_r;
                overrun_r <= overrun_r;
            end
        end
    end

    assign pm.period       = period_r;
    assign pm.period_valid = valid_r;
    assign pm.timeout      = timeout_r;
    assign pm.lock         = lock_r;
    assign pm.overrun      = overrun_r;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: clk_in is generated in lockstep with clk50 and a
// scoreboard queue holds the periods the bench expects to be reported.
`timescale 1ns/1ps
module tb_clk_period_meter;

    localparam int TB_TIMEOUT = 200;

    logic clk50 = 1'b0;
    logic rst_n;
    logic clk_in;
    logic enable;

    int n_checks  = 0;
    int n_fail    = 0;
    int n_xfer    = 0;
    int cyc       = 0;
    int last_rise = 0;
    int xfer_mark = 0;
    bit armed     = 1'b0;
    int sb_q[$];
`ifdef PERIOD_AVG_EN
    int acc_m = 0;
    int acc_n = 0;
`endif

    clk_period_meter_if #(.CNT_W(16)) pm ();

    clk_period_meter #(
        .CNT_W       (16),
        .SYNC_STAGES (2),
        .TIMEOUT     (TB_TIMEOUT)
    ) dut (
        .clk50  (clk50),
        .rst_n  (rst_n),
        .clk_in (clk_in),
        .enable (enable),
        .pm     (pm)
    );

    always #10 clk50 = ~clk50;

    always @(posedge clk50) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk50);
            #1;
        end
    endtask

    // With ready low an unconsumed expectation is replaced, mirroring the overwrite.
    task automatic sb_push(input int v);
        if (pm.period_ready == 1'b0 && sb_q.size() > 0) begin
            sb_q[sb_q.size()-1] = v;
        end else begin
            sb_q.push_back(v);
        end
    endtask

    task automatic model_edge();
        if (armed) begin
`ifdef PERIOD_AVG_EN
            acc_m += cyc - last_rise;
            acc_n++;
            if (acc_n == 4) begin
                sb_push(acc_m >> 2);
                acc_m = 0;
                acc_n = 0;
            end
`else
            sb_push(cyc - last_rise);
`endif
        end
        armed     = 1'b1;
        last_rise = cyc;
    endtask

    task automatic disarm();
        armed = 1'b0;
`ifdef PERIOD_AVG_EN
        acc_m = 0;
        acc_n = 0;
`endif
    endtask

    task automatic do_rise();
        clk_in = 1'b1;
        model_edge();
    endtask

    // n full clk_in periods of p clk50 cycles, each starting with a rise.
    task automatic run_clk(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            do_rise();
            step(p / 2);
            clk_in = 1'b0;
            step(p - p / 2 - 1);
        end
    endtask

    // Scoreboard: every accepted transfer must match the oldest expectation.
    always @(negedge clk50) begin
        if (rst_n === 1'b1 && pm.period_valid === 1'b1 && pm.period_ready === 1'b1) begin
            n_xfer++;
            n_checks++;
            assert (sb_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_report: observed period %0d expected no report", pm.period);
            end
            if (sb_q.size() > 0) begin
                chk("period_value", 32'(pm.period), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no end of test, required end within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n           = 1'b0;
        enable          = 1'b0;
        clk_in          = 1'b0;
        pm.period_ready = 1'b1;
        step(4);
        @(negedge clk50);
        chk("reset_valid",   32'(pm.period_valid), 32'd0);
        chk("reset_period",  32'(pm.period),       32'd0);
        chk("reset_timeout", 32'(pm.timeout),      32'd0);
        chk("reset_lock",    32'(pm.lock),         32'd0);
        chk("reset_overrun", 32'(pm.overrun),      32'd0);
        step(1);
        rst_n = 1'b1;
        step(2);
        enable = 1'b1;
        step(5);

`ifndef PERIOD_AVG_EN
        run_clk(52, 2);
        @(negedge clk50);
        chk("first_period",  32'(pm.period), 32'd52);
        chk("first_no_lock", 32'(pm.lock),   32'd0);
        chk("first_xfers",   32'(n_xfer),    32'd1);

        run_clk(52, 4);
        @(negedge clk50);
        chk("steady_lock",    32'(pm.lock),    32'd1);
        chk("steady_timeout", 32'(pm.timeout), 32'd0);
        chk("steady_overrun", 32'(pm.overrun), 32'd0);

        run_clk(60, 2);
        @(negedge clk50);
        chk("first60_lock",   32'(pm.lock),   32'd0);
        chk("first60_period", 32'(pm.period), 32'd60);
        run_clk(60, 1);
        @(negedge clk50);
        chk("second60_lock", 32'(pm.lock), 32'd1);

        // Stall high; timeout must appear exactly TIMEOUT cycles after detection.
        step(1);
        do_rise();
        repeat (TB_TIMEOUT + 3) @(negedge clk50);
        chk("timeout_early", 32'(pm.timeout), 32'd0);
        @(negedge clk50);
        chk("timeout_fire", 32'(pm.timeout), 32'd1);
        chk("timeout_lock", 32'(pm.lock),    32'd0);
        disarm();
        step(20);
        @(negedge clk50);
        chk("timeout_sticky", 32'(pm.timeout), 32'd1);
        step(1);
        clk_in = 1'b0;
        step(25);
        xfer_mark = n_xfer;
        run_clk(52, 1);
        @(negedge clk50);
        chk("timeout_cleared", 32'(pm.timeout), 32'd0);
        chk("rearm_no_report", 32'(n_xfer),     32'(xfer_mark));
        run_clk(52, 1);
        @(negedge clk50);
        chk("rearm_period",  32'(pm.period), 32'd52);
        chk("rearm_no_lock", 32'(pm.lock),   32'd0);

        step(1);
        pm.period_ready = 1'b0;
        run_clk(40, 4);
        @(negedge clk50);
        chk("ovr_valid",   32'(pm.period_valid), 32'd1);
        chk("ovr_period",  32'(pm.period),       32'd40);
        chk("ovr_overrun", 32'(pm.overrun),      32'd1);
        step(1);
        pm.period_ready = 1'b1;
        step(1);
        pm.period_ready = 1'b0;
        @(negedge clk50);
        chk("accept_valid",  32'(pm.period_valid), 32'd0);
        chk("accept_ovr",    32'(pm.overrun),      32'd1);
        chk("accept_period", 32'(pm.period),       32'd40);
        step(1);
        pm.period_ready = 1'b1;

        // Drop enable mid-period, then re-enable.
        step(5);
        do_rise();
        step(10);
        enable = 1'b0;
        disarm();
        step(3);
        @(negedge clk50);
        chk("idle_valid",   32'(pm.period_valid), 32'd0);
        chk("idle_lock",    32'(pm.lock),         32'd0);
        chk("idle_timeout", 32'(pm.timeout),      32'd0);
        chk("idle_overrun", 32'(pm.overrun),      32'd0);
        step(1);
        enable = 1'b1;
        step(5);
        clk_in = 1'b0;
        step(10);
        xfer_mark = n_xfer;
        run_clk(40, 1);
        @(negedge clk50);
        chk("reenable_no_report", 32'(n_xfer), 32'(xfer_mark));
        run_clk(40, 2);
        @(negedge clk50);
        chk("reenable_period", 32'(pm.period), 32'd40);
        chk("reenable_lock",   32'(pm.lock),   32'd1);
`else
        xfer_mark = n_xfer;
        run_clk(50, 1);
        run_clk(51, 1);
        run_clk(52, 1);
        run_clk(53, 1);
        @(negedge clk50);
        chk("avg_no_intermediate", 32'(n_xfer), 32'(xfer_mark));
        step(1);
        do_rise();
        step(8);
        @(negedge clk50);
        chk("avg_period",  32'(pm.period), 32'd51);
        chk("avg_reports", 32'(n_xfer),    32'(xfer_mark + 1));
        chk("avg_no_lock", 32'(pm.lock),   32'd0);
`endif

        step(10);
        @(negedge clk50);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
